// File: rtl/axi_rd_arb2_pkg.sv
// Shared types, widths and helpers for the two-requester AXI read arbiter.
package axi_rd_arb2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 4;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/axi_rd_arb2_if.sv
// One AXI read port (AR + R channels); master drives AR, slave drives R.
interface axi_rd_arb2_if #(
    parameter int IDW = 5
);
    import axi_rd_arb2_pkg::*;

    logic [IDW-1:0]    arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              aruser;
    logic              arvalid;
    logic              arready;

    logic [IDW-1:0]    rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              ruser;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_arb2_rr_arb2.sv
// Two-way round-robin grant FSM; grant is held until the AR handshake.
module rr_arb2
    import axi_rd_arb2_pkg::*;
(
    input  logic       clk,
    input  logic       sclr,
    input  logic [1:0] req,
    input  logic       done,
    output logic       busy,
    output logic       gsel
);

    state_e state_q, state_d;
    logic   gsel_q, gsel_d;
    logic   prio_q, prio_d;

    always_comb begin
        state_d = state_q;
        gsel_d  = gsel_q;
        prio_d  = prio_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    gsel_d  = req[prio_q] ? prio_q : ~prio_q;
                end
            end
            BUSY: begin
                // Priority flips to whoever was not just served.
                if (done) begin
                    state_d = IDLE;
                    prio_d  = ~gsel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= IDLE;
            gsel_q  <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gsel_q  <= gsel_d;
            prio_q  <= prio_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign gsel = gsel_q;

endmodule

// File: rtl/axi_rd_arb2.sv
// Arbitrates two AXI read requesters onto one master port; the ID MSB
// carries the requester index so R beats route back without lookup.
module axi_rd_arb2
    import axi_rd_arb2_pkg::*;
#(
    parameter int P_AXI_IDWIDTH = 5,
    parameter int P_MAX_OUT     = 4
) (
    input  logic          aclk,
    input  logic          sclr,
    axi_rd_arb2_if.slave  axis0,
    axi_rd_arb2_if.slave  axis1,
    axi_rd_arb2_if.master axim,
    output logic          rd_err
);

    localparam int CW = cnt_width(P_MAX_OUT);
    localparam logic [CW-1:0] MAX_C = CW'(P_MAX_OUT);

    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          rd_err_q, rd_err_d;

    logic [1:0] elig;
    logic [1:0] inc;
    logic [1:0] dec;
    logic       busy;
    logic       gsel;
    logic       ar_hs;
    logic       rsel;
    logic       rdy;
    logic       r_end;

    assign elig[0] = axis0.arvalid & (cnt_q[0] < MAX_C);
    assign elig[1] = axis1.arvalid & (cnt_q[1] < MAX_C);
    assign ar_hs   = busy & axim.arready;

    rr_arb2 u_rr (
        .clk  (aclk),
        .sclr (sclr),
        .req  (elig),
        .done (ar_hs),
        .busy (busy),
        .gsel (gsel)
    );

    assign axim.arvalid = busy;
    assign axim.arid    = {gsel, gsel ? axis1.arid : axis0.arid};
    assign axim.araddr  = gsel ? axis1.araddr  : axis0.araddr;
    assign axim.arlen   = gsel ? axis1.arlen   : axis0.arlen;
    assign axim.arsize  = gsel ? axis1.arsize  : axis0.arsize;
    assign axim.arburst = gsel ? axis1.arburst : axis0.arburst;
    assign axim.arlock  = gsel ? axis1.arlock  : axis0.arlock;
    assign axim.arcache = gsel ? axis1.arcache : axis0.arcache;
    assign axim.arprot  = gsel ? axis1.arprot  : axis0.arprot;
    assign axim.aruser  = gsel ? axis1.aruser  : axis0.aruser;

    assign axis0.arready = busy & ~gsel & axim.arready;
    assign axis1.arready = busy &  gsel & axim.arready;

    assign rsel = axim.rid[P_AXI_IDWIDTH];
    assign rdy  = rsel ? axis1.rready : axis0.rready;

    assign axim.rready  = rdy;
    assign axis0.rvalid = axim.rvalid & ~rsel;
    assign axis1.rvalid = axim.rvalid &  rsel;

    assign axis0.rid   = axim.rid[P_AXI_IDWIDTH-1:0];
    assign axis1.rid   = axim.rid[P_AXI_IDWIDTH-1:0];
    assign axis0.rdata = axim.rdata;
    assign axis1.rdata = axim.rdata;
    assign axis0.rresp = axim.rresp;
    assign axis1.rresp = axim.rresp;
    assign axis0.rlast = axim.rlast;
    assign axis1.rlast = axim.rlast;
    assign axis0.ruser = axim.ruser;
    assign axis1.ruser = axim.ruser;

    assign r_end = axim.rvalid & rdy & axim.rlast;
    assign inc   = {ar_hs & gsel, ar_hs & ~gsel};
    assign dec   = {r_end & rsel, r_end & ~rsel};

    always_comb begin
        rd_err_d = rd_err_q;
        for (int n = 0; n < 2; n++) begin
            cnt_d[n] = cnt_q[n];
            if (inc[n] & ~dec[n]) begin
                cnt_d[n] = cnt_q[n] + 1'b1;
            end else if (dec[n] & ~inc[n]) begin
                // Burst end with nothing outstanding: saturate, flag it.
                if (cnt_q[n] == '0) begin
                    rd_err_d = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (sclr) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            rd_err_q <= 1'b0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_err = rd_err_q;

endmodule

// File: doc/axi_rd_arb2.md
AXI_RD_ARB2 -- requirements
Module: axi_rd_arb2

Interface
REQ-001 The block SHALL have parameter P_AXI_IDWIDTH, default 5, giving the slave-side ID width; the master-side ID is P_AXI_IDWIDTH+1 bits wide.
REQ-002 The block SHALL have parameter P_MAX_OUT, default 4, giving the maximum outstanding read bursts per requester (range 1..15).
REQ-003 The block SHALL have ports:
- aclk  in  1  clock; one clock only.
- sclr  in  1  reset; synchronous, active-high.
- axisN_arid  in  P_AXI_IDWIDTH  requester N read ID (N=0,1).
- axisN_araddr  in  32  address.
- axisN_arlen  in  4  burst length-1.
- axisN_arsize  in  3  size.
- axisN_arburst  in  2  burst type.
- axisN_arlock  in  1  lock.
- axisN_arcache  in  4  cache.
- axisN_arprot  in  3  protection.
- axisN_aruser  in  1  user.
- axisN_arvalid  in  1  address valid.
- axisN_arready  out  1  address ready.
- axisN_rid  out  P_AXI_IDWIDTH  read ID.
- axisN_rdata  out  64  data.
- axisN_rresp  out  2  response.
- axisN_rlast  out  1  last beat.
- axisN_ruser  out  1  user.
- axisN_rvalid  out  1  data valid.
- axisN_rready  in  1  data ready.
- axim_ar*  out  same widths, except axim_arid is P_AXI_IDWIDTH+1  shared AR channel; axim_arready is an input.
- axim_r*  in  same widths, except axim_rid is P_AXI_IDWIDTH+1  shared R channel; axim_rready is an output.
- rd_err  out  1  sticky: R beat received for a requester with zero outstanding bursts.

Function
REQ-004 The arbiter SHALL have two states: IDLE and BUSY, with a registered grant index gsel.
REQ-005 In IDLE, the arbiter SHALL treat requester N as eligible when axisN_arvalid=1 and cntN<P_MAX_OUT.
REQ-006 In IDLE with at least one eligible requester, the arbiter SHALL pick one by round-robin, register it in gsel, and move to BUSY on the next edge.
- Round-robin: priority goes to the requester not granted last; after reset requester 0 has priority.
REQ-007 In BUSY, the arbiter SHALL drive axim_arvalid=1 and the axim_ar* fields from requester gsel.
- axim_arid = {gsel, axisgsel_arid}.
- axisgsel_arready = axim_arready.
- The other requester's arready = 0.
REQ-008 The arbiter SHALL return to IDLE on the edge where axim_arvalid & axim_arready, and SHALL toggle the priority to the other requester.
REQ-009 In IDLE, the arbiter SHALL hold axim_arvalid=0 and both axisN_arready=0.
- AR latency is 1 cycle from eligible arvalid to axim_arvalid.
- Peak AR throughput is one address per 2 cycles.
REQ-010 The R channel SHALL be routed combinationally by d = axim_rid[P_AXI_IDWIDTH]:
- axisd_rvalid = axim_rvalid.
- The other requester's rvalid = 0.
- axim_rready = axisd_rready.
- axisN_rid = axim_rid[P_AXI_IDWIDTH-1:0].
- rdata, rresp, rlast and ruser are broadcast to both requesters.
REQ-011 The counter cntN SHALL increment on the AR handshake granted to N and decrement on an R handshake with rlast=1 routed to N.
- Simultaneous increment and decrement leave the counter unchanged.
- Counter width is clog2(P_MAX_OUT+1).
REQ-012 A decrement when cntN=0 SHALL leave cntN at 0 and set rd_err=1 until sclr.
REQ-013 The arbiter SHALL never increment cntN beyond P_MAX_OUT; REQ-005 blocks the grant instead.
REQ-014 An arvalid deasserted by a requester in BUSY is a protocol violation; the grant SHALL still be held until the axim handshake.

Reset
REQ-015 While sclr=1 at an aclk edge:
- state = IDLE, gsel = 0, priority = requester 0, cnt0 = cnt1 = 0, rd_err = 0.
- axim_arvalid = 0 and axisN_arready = 0 from that edge on.
REQ-016 When sclr is asserted mid-burst, the arbiter SHALL discard the outstanding counts; R routing stays combinational and unaffected.

Structure
REQ-017 A shared package axi_rd_arb2_pkg SHALL hold:
- the state enum (IDLE, BUSY);
- the widths: address 32, data 64, len 4;
- the function computing the counter width from P_MAX_OUT.
REQ-018 One sub-module, rr_arb2, SHALL hold the 2-way round-robin pointer and the grant logic; the counters and the R routing stay in the top level.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single request: axis0_arvalid, arid=3 -> axim_arvalid one cycle later, axim_arid=6'h03; after arready, cnt0=1.
- Contention: both arvalid held, arready=1 -> grants in order 0,1,0,1; arids carry MSB 0,1,0,1.
- Limit: P_MAX_OUT=4, no R returned, requester 0 streaming -> exactly 4 AR handshakes, then axim_arvalid stays 0; one rlast to 0 -> a 5th grant follows.
- Interleaved R: axim_rid=6'h25, rlast=1, axis1_rready=0 -> axis1_rvalid=1, axim_rready=0, axis0_rvalid=0; raising rready gives cnt1-1.
- Simultaneous: AR grant to 1 and rlast to 1 on the same edge -> cnt1 unchanged.
- Error/reset: rlast to 0 with cnt0=0 -> rd_err=1 and cnt0=0; sclr pulse in BUSY -> axim_arvalid=0 next cycle, all counts 0, rd_err=0.
